// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues imem requests and buffers
// returned instructions in an in-order queue presented to decode.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        q_mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] discard;
  logic [CW:0]   used;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic          grant;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;

  assign used = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_o  = rst_ni && !redirect_i && (used < LIMIT);
  assign imem_addr_o = fetch_pc;

  assign grant = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding belongs to a pre-reset request.
  assign rsp   = imem_rvalid_i && (outstanding != '0);
  assign drop  = rsp && (redirect_i || (discard != '0));
  assign push  = rsp && !drop;

  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;

  assign head    = q_mem[rd_ptr];
  assign instr_o = valid_o ? head.instr : '0;
  assign pc_o    = valid_o ? head.pc : '0;
  assign pc4_o   = valid_o ? head.pc + 32'd4 : '0;

  always_comb begin
    out_nxt   = outstanding + CW'(grant) - CW'(rsp);
    count_nxt = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + 1'b1;
      pop && !push: count_nxt = count - 1'b1;
      default:      count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= out_nxt;
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (redirect_i) begin
        // Everything still in flight is old-path and must be dropped.
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        discard  <= out_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (rsp && (discard != '0)) discard <= discard - 1'b1;
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      q_mem[wr_ptr] <= '{instr: imem_rdata_i, pc: resp_pc};
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order imem model
// whose latency is captured per request at grant time.
module tb_fetch_prefetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;

  int n_checks = 0;
  int n_fail = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc4_o(pc4_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  always @(posedge clk_i) begin
    if (imem_req_o && imem_gnt_i) pend.push_back('{imem_addr_o, cyc + lat});
    cyc = cyc + 1;
    #1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_ni = 1'b0; redirect_i = 1'b0;
    imem_gnt_i = 1'b0; ready_i = 1'b0; lat = 1;
    repeat (2) next_cycle();
    @(negedge clk_i);
    pend.delete();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) next_cycle();
    @(negedge clk_i);
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr_o); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    n_checks++; if (pc4_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", pc4_o); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk_i);
      n_checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4*i)) begin
        n_fail++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", i, imem_req_o, imem_addr_o, 4*i);
      end
      if (i < 2) begin
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid[%0d]: got %b want 0", i, valid_o); end
      end else begin
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'(4*(i-2))) begin
          n_fail++; $display("FAIL stream_pc[%0d]: got %b/%h want 1/%h", i, valid_o, pc_o, 4*(i-2));
        end
        n_checks++; if (pc4_o !== 32'(4*(i-1))) begin n_fail++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, pc4_o, 4*(i-1)); end
        n_checks++; if (instr_o !== mem_word(32'(4*(i-2)))) begin
          n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr_o, mem_word(32'(4*(i-2))));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    imem_gnt_i = 1'b1; ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk_i);
      if (imem_req_o && imem_gnt_i) grants++;
    end
    n_checks++; if (grants != 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", grants); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_full: got %b want 0", imem_req_o); end
    next_cycle(); ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_c7: got %b want 0", imem_req_o); end
    n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL bp_pop0: got %b/%h want 1/0", valid_o, pc_o); end
    next_cycle(); @(negedge clk_i);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      n_fail++; $display("FAIL bp_req_c8: got %b/%h want 1/10", imem_req_o, imem_addr_o);
    end
    n_checks++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL bp_pop1: got %h want 4", pc_o); end
    next_cycle(); @(negedge clk_i);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14) begin
      n_fail++; $display("FAIL bp_req_c9: got %b/%h want 1/14", imem_req_o, imem_addr_o);
    end
    n_checks++; if (pc_o !== 32'h8) begin n_fail++; $display("FAIL bp_pop2: got %h want 8", pc_o); end
    next_cycle(); @(negedge clk_i);
    n_checks++; if (pc_o !== 32'hC || instr_o !== mem_word(32'hC)) begin
      n_fail++; $display("FAIL bp_pop3: got %h/%h want c/%h", pc_o, instr_o, mem_word(32'hC));
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    ready_i = 1'b1; imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk_i);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/0", i, imem_req_o, imem_addr_o);
      end
    end
    next_cycle(); imem_gnt_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL stall_grant_addr: got %h want 0", imem_addr_o); end
    next_cycle(); @(negedge clk_i);
    n_checks++; if (imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL stall_next_addr: got %h want 4", imem_addr_o); end
  endtask

  task automatic test_redirect_stale();
    bit found = 1'b0;
    do_reset();
    lat = 5; imem_gnt_i = 1'b1; ready_i = 1'b1;
    repeat (3) next_cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk_i);
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stale_req_redirect: got %b want 0", imem_req_o); end
    next_cycle(); redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL stale_restart: got %b/%h want 1/100", imem_req_o, imem_addr_o);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      next_cycle(); @(negedge clk_i);
      if (valid_o) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stale_timeout: got no valid want valid"); end
    n_checks++; if (pc_o !== 32'h100 || pc4_o !== 32'h104) begin
      n_fail++; $display("FAIL stale_first_pc: got %h/%h want 100/104", pc_o, pc4_o);
    end
    n_checks++; if (instr_o !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL stale_first_instr: got %h want %h", instr_o, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_collision();
    bit found = 1'b0;
    do_reset();
    lat = 2; imem_gnt_i = 1'b1; ready_i = 1'b1;
    repeat (3) next_cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
      n_fail++; $display("FAIL coll_head: got %b/%h want 1/0", valid_o, pc_o);
    end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL coll_req: got %b want 0", imem_req_o); end
    next_cycle(); redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL coll_flushed: got %b/%h want 0", valid_o, pc_o); end
    for (int i = 0; i < 20 && !found; i++) begin
      next_cycle(); @(negedge clk_i);
      if (valid_o) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL coll_timeout: got no valid want valid"); end
    n_checks++; if (pc_o !== 32'h200 || instr_o !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL coll_first: got %h/%h want 200/%h", pc_o, instr_o, mem_word(32'h200));
    end
  endtask

  task automatic test_reset_inflight();
    bit found = 1'b0;
    do_reset();
    lat = 1; imem_gnt_i = 1'b1; ready_i = 1'b1;
    next_cycle(); lat = 6;
    next_cycle(); ready_i = 1'b0; rst_ni = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_pre_head: got %b/%h want 1/0", valid_o, pc_o);
    end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_low: got %b want 0", imem_req_o); end
    next_cycle(); rst_ni = 1'b1; imem_gnt_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || pc4_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_outputs: got %b/%h/%h/%h want 0/0/0/0", valid_o, instr_o, pc_o, pc4_o);
    end
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_restart: got %b/%h want 1/0", imem_req_o, imem_addr_o);
    end
    for (int i = 0; i < 7; i++) begin
      next_cycle(); @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid[%0d]: got %b/%h want 0", i, valid_o, pc_o); end
    end
    next_cycle(); lat = 1; imem_gnt_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle(); @(negedge clk_i);
      if (valid_o) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_timeout: got no valid want valid"); end
    n_checks++; if (pc_o !== 32'h0 || pc4_o !== 32'h4 || instr_o !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL rst_first: got %h/%h/%h want 0/4/%h", pc_o, pc4_o, instr_o, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect_stale();
    test_redirect_collision();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
